// File: rtl/radio_frame_sched.sv
// radio_frame_sched: slot-based serial frame builder with sample FIFO; optional CRC slot via RADIO_FRAME_CRC_EN
module radio_frame_sched #(
  parameter logic [7:0] SYNC_WORD  = 8'hA5,
  parameter int         DATA_SLOTS = 16,
  parameter logic [7:0] FILL_WORD  = 8'hFF,
  parameter logic [7:0] HK_IDLE    = 8'h00
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] SAMPLE,
  input  logic       SAMPLE_VALID,
  input  logic [7:0] HK_DATA,
  input  logic       HK_REQ,
  output logic       HK_ACK,
  output logic       DATA_OUT,
  output logic       SYNC,
  output logic       MISC,
  output logic [7:0] OVF_CNT
);
  typedef enum logic [2:0] {
    IDLE,
    SYNC_SLOT,
    HK_SLOT,
    DATA_SLOT
`ifdef RADIO_FRAME_CRC_EN
    , CRC_SLOT
`endif
  } state_t;
  state_t state, state_nxt, frame_next;
  logic [2:0] bit_cnt;
  logic [7:0] slot_cnt;
  logic [7:0] word, word_nxt, tail_word;
  logic       slot_end, last_data, enter;
  logic [7:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic       full, empty, push, pop, push_ok;
`ifdef RADIO_FRAME_CRC_EN
  logic [7:0] crc, crc_nxt;
  logic       fb;
  // serial CRC-8 (x^8+x^2+x+1) over the bit currently on the line in HK and data slots
  always_comb begin
    fb = crc[7] ^ word[bit_cnt];
    crc_nxt = (state == HK_SLOT || state == DATA_SLOT) ? ({crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00)) : crc;
    tail_word = crc_nxt;
  end
  // CRC restarts every frame during the sync slot
  always_ff @(posedge SYS_CLK or negedge RST_N)
    if (!RST_N) crc <= 8'h00;
    else crc <= (state == SYNC_SLOT) ? 8'h00 : crc_nxt;
`else
  assign tail_word = 8'h00;
`endif
  // slot sequencing, slot word selection and FIFO handshakes
  always_comb begin
    slot_end = (state != IDLE) && (bit_cnt == 3'd7);
    last_data = slot_cnt == 8'(DATA_SLOTS - 1);
    frame_next = EN ? SYNC_SLOT : IDLE;
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = frame_next;
      SYNC_SLOT: if (slot_end) state_nxt = HK_SLOT;
      HK_SLOT:   if (slot_end) state_nxt = DATA_SLOT;
`ifdef RADIO_FRAME_CRC_EN
      DATA_SLOT: if (slot_end && last_data) state_nxt = CRC_SLOT;
      CRC_SLOT:  if (slot_end) state_nxt = frame_next;
`else
      DATA_SLOT: if (slot_end && last_data) state_nxt = frame_next;
`endif
      default:   state_nxt = IDLE;
    endcase
    enter = (state == IDLE) ? EN : (slot_end && state_nxt != IDLE);
    full = count == 3'd4;
    empty = count == 3'd0;
    pop = enter && state_nxt == DATA_SLOT && !empty;
    push = SAMPLE_VALID && state != IDLE;
    push_ok = push && (!full || pop);
    word_nxt = (state_nxt == SYNC_SLOT) ? SYNC_WORD :
               (state_nxt == HK_SLOT)   ? (HK_REQ ? HK_DATA : HK_IDLE) :
               (state_nxt == DATA_SLOT) ? (empty ? FILL_WORD : mem[rd_ptr]) : tail_word;
  end
  // state, bit/slot counters and registered line outputs
  always_ff @(posedge SYS_CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      slot_cnt <= 8'd0;
      word <= 8'h00;
      DATA_OUT <= 1'b0;
      SYNC <= 1'b0;
      MISC <= 1'b0;
      HK_ACK <= 1'b0;
    end else begin
      state <= state_nxt;
      bit_cnt <= (state == IDLE || state_nxt == IDLE) ? 3'd0 : bit_cnt + 3'd1;
      slot_cnt <= (state_nxt == HK_SLOT) ? 8'd0 : (state == DATA_SLOT && slot_end) ? slot_cnt + 8'd1 : slot_cnt;
      if (enter) word <= word_nxt;
      DATA_OUT <= (state_nxt == IDLE) ? 1'b0 : enter ? word_nxt[0] : word[bit_cnt + 3'd1];
      SYNC <= enter && state_nxt == SYNC_SLOT;
      MISC <= (state_nxt == IDLE) ? 1'b0 : enter ? (state_nxt == DATA_SLOT && empty) : MISC;
      HK_ACK <= enter && state_nxt == HK_SLOT && HK_REQ;
    end
  // FIFO pointers and occupancy; flushed whenever the scheduler is idle
  always_ff @(posedge SYS_CLK or negedge RST_N)
    if (!RST_N) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count <= 3'd0;
    end else if (state_nxt == IDLE) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  // FIFO storage; head is read before a same-edge write into a full FIFO lands
  always_ff @(posedge SYS_CLK)
    if (push_ok && state_nxt != IDLE) mem[wr_ptr] <= SAMPLE;
  // saturating drop counter, cleared only by reset
  always_ff @(posedge SYS_CLK or negedge RST_N)
    if (!RST_N) OVF_CNT <= 8'h00;
    else if (push && full && !pop && OVF_CNT != 8'hFF) OVF_CNT <= OVF_CNT + 8'h01;
endmodule

// File: tb/tb_radio_frame_sched.sv
// tb_radio_frame_sched: directed frame-level checks of radio_frame_sched
module tb_radio_frame_sched;
`ifdef RADIO_FRAME_CRC_EN
  localparam int NS = 19;
  localparam logic [7:0] FILL = 8'h00;
`else
  localparam int NS = 18;
  localparam logic [7:0] FILL = 8'hFF;
`endif
  logic sys_clk = 1'b0, rst_n = 1'b0, en = 1'b0, sample_valid = 1'b0, hk_req = 1'b0;
  logic [7:0] sample = 8'h00, hk_data = 8'h00;
  logic hk_ack, data_out, sync, misc;
  logic [7:0] ovf_cnt;
  logic [7:0] fr [NS];
  int n_chk = 0, n_pass = 0;
  int sync_cnt, sync_bad, misc_cnt, ack_cnt, act;
  logic [7:0] exp_crc;
  always #5 sys_clk = ~sys_clk;
  radio_frame_sched #(.FILL_WORD(FILL)) dut (
    .SYS_CLK(sys_clk), .RST_N(rst_n), .EN(en), .SAMPLE(sample), .SAMPLE_VALID(sample_valid),
    .HK_DATA(hk_data), .HK_REQ(hk_req), .HK_ACK(hk_ack), .DATA_OUT(data_out), .SYNC(sync),
    .MISC(misc), .OVF_CNT(ovf_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction
  task automatic read_frame;
    sync_cnt = 0; sync_bad = 0; misc_cnt = 0; ack_cnt = 0;
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < 8; b++) begin
        @(negedge sys_clk);
        fr[s][b] = data_out;
        if (sync) begin
          sync_cnt++;
          if (s != 0 || b != 0) sync_bad++;
        end
        misc_cnt += int'(misc);
        ack_cnt += int'(hk_ack);
      end
  endtask
  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; hk_req = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask
  initial begin
    repeat (2) @(negedge sys_clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_sync", sync, 0);
    chk("rst_misc", misc, 0);
    chk("rst_hk_ack", hk_ack, 0);
    chk("rst_ovf", ovf_cnt, 0);
    // basic frame
    do_reset;
    en = 1'b1;
    read_frame;
    chk("sync_word", fr[0], 8'hA5);
    chk("sync_cnt", sync_cnt, 1);
    chk("sync_pos", sync_bad, 0);
    chk("hk_idle", fr[1], 8'h00);
    for (int s = 2; s < 18; s++) chk($sformatf("fill_%0d", s), fr[s], FILL);
    chk("misc_cnt", misc_cnt, 128);
    chk("no_ack", ack_cnt, 0);
    read_frame;
    chk("sync_word_f2", fr[0], 8'hA5);
    chk("sync_cnt_f2", sync_cnt, 1);
    // samples and housekeeping
    do_reset;
    en = 1'b1; hk_req = 1'b1; hk_data = 8'h5C;
    fork
      read_frame;
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge sys_clk);
          sample = 8'(8'h11 * (i + 1)); sample_valid = 1'b1;
        end
        @(negedge sys_clk);
        sample_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20 && hk_req; i++) begin
          @(negedge sys_clk);
          if (hk_ack) hk_req = 1'b0;
        end
        hk_req = 1'b0;
      end
    join
    chk("hk_byte", fr[1], 8'h5C);
    chk("hk_ack_cnt", ack_cnt, 1);
    chk("smp0", fr[2], 8'h11);
    chk("smp1", fr[3], 8'h22);
    chk("smp2", fr[4], 8'h33);
    for (int s = 5; s < 18; s++) chk($sformatf("smp_fill_%0d", s), fr[s], FILL);
    chk("smp_misc_cnt", misc_cnt, 104);
    // overflow
    do_reset;
    en = 1'b1;
    fork
      read_frame;
      begin
        for (int i = 1; i <= 7; i++) begin
          @(negedge sys_clk);
          sample = 8'(i); sample_valid = 1'b1;
        end
        @(negedge sys_clk);
        sample_valid = 1'b0;
      end
    join
    chk("ovf_cnt", ovf_cnt, 3);
    for (int s = 2; s < 6; s++) chk($sformatf("ovf_slot_%0d", s), fr[s], s - 1);
    chk("ovf_fill", fr[6], FILL);
    // full FIFO with push on the data-slot entry edge, then a push that must drop
    do_reset;
    en = 1'b1;
    fork
      read_frame;
      begin
        for (int i = 1; i <= 4; i++) begin
          @(negedge sys_clk);
          sample = 8'(i); sample_valid = 1'b1;
        end
        @(negedge sys_clk);
        sample_valid = 1'b0;
        repeat (11) @(negedge sys_clk);
        sample = 8'h99; sample_valid = 1'b1;
        @(negedge sys_clk);
        sample = 8'hAA;
        @(negedge sys_clk);
        sample_valid = 1'b0;
      end
    join
    chk("pp_ovf", ovf_cnt, 1);
    for (int s = 2; s < 6; s++) chk($sformatf("pp_slot_%0d", s), fr[s], s - 1);
    chk("pp_pushed", fr[6], 8'h99);
    chk("pp_fill", fr[7], FILL);
    // stop mid-frame: frame completes, then quiet
    do_reset;
    en = 1'b1;
    fork
      read_frame;
      begin
        repeat (41) @(negedge sys_clk);
        en = 1'b0;
      end
    join
    chk("stop_sync", fr[0], 8'hA5);
    chk("stop_last", fr[17], FILL);
    chk("stop_misc", misc_cnt, 128);
    act = 0;
    repeat (16) begin
      @(negedge sys_clk);
      act += int'(data_out) + int'(sync) + int'(misc) + int'(hk_ack);
    end
    chk("stop_quiet", act, 0);
    // asynchronous reset mid-slot
    do_reset;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      sample = 8'(i + 1); sample_valid = 1'b1;
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
    repeat (44) @(negedge sys_clk);
    chk("pre_rst_misc", misc, 1);
    chk("pre_rst_ovf", ovf_cnt, 2);
    chk("pre_rst_data", data_out, FILL[2]);
    #2 rst_n = 1'b0; en = 1'b0;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_misc", misc, 0);
    chk("arst_ovf", ovf_cnt, 0);
    chk("arst_sync", sync, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    act = 0;
    repeat (3) begin
      @(negedge sys_clk);
      act += int'(data_out) + int'(sync) + int'(misc);
    end
    chk("post_rst_quiet", act, 0);
    en = 1'b1;
    @(negedge sys_clk);
    chk("restart_sync", sync, 1);
    chk("restart_bit0", data_out, 1);
`ifdef RADIO_FRAME_CRC_EN
    do_reset;
    en = 1'b1;
    read_frame;
    chk("crc_zero", fr[NS-1], 8'h00);
    do_reset;
    en = 1'b1;
    fork
      read_frame;
      begin
        @(negedge sys_clk);
        sample = 8'h01; sample_valid = 1'b1;
        @(negedge sys_clk);
        sample_valid = 1'b0;
      end
    join
    exp_crc = crc_byte(8'h00, 8'h00);
    exp_crc = crc_byte(exp_crc, 8'h01);
    for (int i = 0; i < 15; i++) exp_crc = crc_byte(exp_crc, 8'h00);
    chk("crc_nonzero", fr[NS-1] != 8'h00, 1);
    chk("crc_val", fr[NS-1], exp_crc);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/radio_frame_sched.md
# radio_frame_sched

Frame scheduler for the serial radio sample link. It sits between the sample latch and the serial line driver, all on the fast serial clock. Each output frame is built from slots: a sync word, one housekeeping slot shared with the control microcontroller, then a fixed number of sample slots fed from a 4-deep FIFO. Fill words are inserted when samples run short, and overflow is counted when samples arrive faster than slots drain.

## Interface
- `SYNC_WORD`, default 8'hA5: value sent in the sync slot.
- `DATA_SLOTS`, default 16: number of sample slots per frame, range 1..255.
- `FILL_WORD`, default 8'hFF: value sent in a sample slot when the FIFO is empty.
- `HK_IDLE`, default 8'h00: value sent in the HK slot when no request is pending.

Ports:
- `SYS_CLK` in 1: serial bit clock; one bit per cycle.
- `RST_N` in 1: asynchronous, active-low reset.
- `EN` in 1: run enable.
- `SAMPLE` in 8: packed sample word {R0_I, R0_Q, R1_I, R1_Q}.
- `SAMPLE_VALID` in 1: one-cycle push strobe for `SAMPLE`.
- `HK_DATA` in 8: housekeeping byte.
- `HK_REQ` in 1: housekeeping request; held until acknowledged.
- `HK_ACK` out 1: one-cycle pulse when `HK_DATA` is captured.
- `DATA_OUT` out 1: serial data, LSB first.
- `SYNC` out 1: high on bit 0 of each sync slot.
- `MISC` out 1: high for all 8 cycles of every fill slot.
- `OVF_CNT` out 8: saturating count of dropped samples.

## Operation
- FSM states: IDLE, SYNC_SLOT, HK_SLOT, DATA_SLOT, CRC_SLOT (CRC_SLOT exists only with the macro).
- Slot mechanics:
  - Every slot lasts exactly 8 cycles; `bit_cnt` runs 0..7.
  - The slot word is selected and latched on the edge that enters the slot.
  - `DATA_OUT` = word[`bit_cnt`], registered.
- IDLE:
  - Outputs are 0 and the FIFO is held empty; `SAMPLE_VALID` is ignored.
  - If `EN`=1 at a clock edge, the FSM enters SYNC_SLOT at that edge.
- Slot sequence:
  - SYNC_SLOT → HK_SLOT → DATA_SLOT ×`DATA_SLOTS` → (CRC_SLOT) → SYNC_SLOT.
  - At the end of a frame's last slot, if `EN`=0 the FSM goes to IDLE instead of SYNC_SLOT.
  - `EN` is sampled only at that point. A frame in progress always completes.
- HK slot arbitration:
  - If `HK_REQ`=1 on the entering edge, the word is `HK_DATA` and `HK_ACK` pulses in the first cycle of the slot.
  - Otherwise the word is `HK_IDLE`.
  - At most one HK byte is sent per frame.
- DATA_SLOT:
  - If the FIFO is non-empty on the entering edge, pop the head and use it as the word.
  - Otherwise use `FILL_WORD` and hold `MISC`=1 for the slot.
- FIFO:
  - Depth 4, first-word fall-through internally.
  - A push and a pop on the same edge while the FIFO is full are both accepted; nothing is dropped.
  - A push while full with no pop is dropped and `OVF_CNT` increments, saturating at 255.
  - A push and pop on the same edge while empty: the pop misses, so the slot sends fill, and the push is stored.
- `OVF_CNT` clears only on reset.

## Timing
- Reset values:
  - `DATA_OUT`, `SYNC`, `MISC`, `HK_ACK` = 0; `OVF_CNT` = 0.
  - FSM in IDLE, FIFO empty, `bit_cnt` = 0.
- Reset asserted mid-frame clears everything immediately. The first frame after release starts only when `EN` is sampled.
- Latency:
  - Edge that samples `EN`=1 in IDLE → `SYNC`=1 and `DATA_OUT`=`SYNC_WORD`[0] in the following cycle, i.e. the outputs are valid after that edge.
  - A sample pushed at edge N is transmitted no earlier than the next DATA_SLOT entry after N.
- Frame length: (2+`DATA_SLOTS`)×8 cycles, which is 144 cycles at the defaults; 152 with CRC.
- Throughput: sustainable sample rate is `DATA_SLOTS`/((2+`DATA_SLOTS`)×8) per cycle. Upstream must stay below it on average.

## Configuration
- Macro: `RADIO_FRAME_CRC_EN`.
- With the macro defined:
  - CRC_SLOT is appended after the last DATA_SLOT.
  - CRC-8, polynomial x^8+x^2+x+1, init 0x00, is computed over the HK and data slot bits in transmission order, including fill words.
  - The CRC register is sent LSB first and reset to 0 at each SYNC_SLOT.
- Without the macro: no CRC state or logic, and frames have no CRC slot.

## Test plan
- **Basic frame**: reset, then `EN`=1 with no samples and no HK.
  - `DATA_OUT` is 0xA5 LSB first with `SYNC` on its bit 0.
  - Then 0x00 (HK idle), then 16 slots of 0xFF.
  - `MISC` is high for 128 cycles; the frame repeats every 144 cycles.
- **Samples and HK**: push 0x11, 0x22, 0x33 before the first DATA_SLOT and raise `HK_REQ` with `HK_DATA`=0x5C.
  - HK slot carries 0x5C with a single `HK_ACK` pulse.
  - Data slots carry 0x11, 0x22, 0x33, then 0xFF ×13.
- **Overflow**: push 7 samples back-to-back during the sync slot.
  - 4 are stored; `OVF_CNT`=3.
  - Data slots carry the first 4 samples in order.
- **Full with simultaneous push/pop**: FIFO full, push on the DATA_SLOT entry edge.
  - No drop: `OVF_CNT` unchanged and the FIFO is still full.
- **Stop and reset**:
  - Drop `EN` in slot 5: the frame completes through slot 18, then outputs stay 0.
  - Assert `RST_N` mid-slot: all outputs are 0 within the same cycle.
- **CRC** (`RADIO_FRAME_CRC_EN`): `HK_IDLE`=0x00 and `FILL_WORD` overridden to 0x00, no samples.
  - CRC slot = 0x00.
  - With one sample 0x01 in the first data slot, CRC slot ≠ 0x00 and matches the bench reference model.
